// File: rtl/cordic_stage_hs.sv
// cordic_stage_hs: one CORDIC micro-rotation on X/Y/Z with rotation or
// vectoring select, saturating X/Y and a two-entry skid on the output.
module cordic_stage_hs #(
    parameter int XY_W  = 16,
    parameter int Z_W   = 16,
    parameter int SHIFT = 0,
    parameter int ATAN  = 8192,
    parameter int ROUND = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [XY_W-1:0] in_x,
    input  logic signed [XY_W-1:0] in_y,
    input  logic signed [Z_W-1:0]  in_z,
    input  logic                   in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [XY_W-1:0] out_x,
    output logic signed [XY_W-1:0] out_y,
    output logic signed [Z_W-1:0]  out_z,
    output logic                   out_mode,
    output logic                   out_ovf
);
    localparam int W1  = XY_W + 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam int RW  = 2 * XY_W + Z_W + 2;

    localparam logic signed [W1-1:0] RND =
        (ROUND != 0 && SHIFT > 0) ? (W1'(1) << RSH) : '0;
    localparam logic signed [XY_W-1:0] XY_MAX = {1'b0, {(XY_W-1){1'b1}}};
    localparam logic signed [XY_W-1:0] XY_MIN = {1'b1, {(XY_W-1){1'b0}}};
    localparam logic signed [Z_W-1:0]  ATAN_Z = Z_W'(ATAN);

    logic                   w_neg;
    logic                   w_acc;
    logic signed [W1-1:0]   w_xe;
    logic signed [W1-1:0]   w_ye;
    logic signed [W1-1:0]   w_xs;
    logic signed [W1-1:0]   w_ys;
    logic signed [W1-1:0]   w_xn;
    logic signed [W1-1:0]   w_yn;
    logic                   w_ox;
    logic                   w_oy;
    logic signed [XY_W-1:0] w_xo;
    logic signed [XY_W-1:0] w_yo;
    logic signed [Z_W-1:0]  w_zo;
    logic [RW-1:0]          w_res;

    logic [RW-1:0]          r_or;
    logic [RW-1:0]          r_sr;
    logic                   r_or_v;
    logic                   r_sr_v;

    // w_neg selects sigma = -1
    assign w_neg = in_mode ? (!in_y[XY_W-1] && (in_y != '0))
                           : in_z[Z_W-1];

    assign w_xe = {in_x[XY_W-1], in_x};
    assign w_ye = {in_y[XY_W-1], in_y};
    assign w_xs = (w_xe + RND) >>> SHIFT;
    assign w_ys = (w_ye + RND) >>> SHIFT;

    assign w_xn = w_neg ? (w_xe + w_ys) : (w_xe - w_ys);
    assign w_yn = w_neg ? (w_ye - w_xs) : (w_ye + w_xs);

    assign w_ox = w_xn[W1-1] ^ w_xn[W1-2];
    assign w_oy = w_yn[W1-1] ^ w_yn[W1-2];
    assign w_xo = w_ox ? (w_xn[W1-1] ? XY_MIN : XY_MAX) : w_xn[XY_W-1:0];
    assign w_yo = w_oy ? (w_yn[W1-1] ? XY_MIN : XY_MAX) : w_yn[XY_W-1:0];
    assign w_zo = w_neg ? (in_z + ATAN_Z) : (in_z - ATAN_Z);

    assign w_res = {w_ox | w_oy, in_mode, w_zo, w_yo, w_xo};
    assign w_acc = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_or   <= '0;
            r_sr   <= '0;
            r_or_v <= 1'b0;
            r_sr_v <= 1'b0;
        end else if (!r_or_v || out_ready) begin
            if (r_sr_v) begin
                r_or   <= r_sr;
                r_or_v <= 1'b1;
                r_sr_v <= 1'b0;
            end else if (w_acc) begin
                r_or   <= w_res;
                r_or_v <= 1'b1;
            end else begin
                r_or_v <= 1'b0;
            end
        end else if (w_acc) begin
            r_sr   <= w_res;
            r_sr_v <= 1'b1;
        end
    end

    assign in_ready  = ~r_sr_v;
    assign out_valid = r_or_v;
    assign out_x     = r_or[0 +: XY_W];
    assign out_y     = r_or[XY_W +: XY_W];
    assign out_z     = r_or[2*XY_W +: Z_W];
    assign out_mode  = r_or[RW-2];
    assign out_ovf   = r_or[RW-1];

endmodule
